// File: rtl/aoi_chk.sv
// In-circuit checker for a 2-2 AND-OR-INVERT cell: waits for the stimulus to
// settle, compares the observed responses against the AOI truth table and
// accumulates coverage and error results.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | no run; results held from the last run (or reset)
// S_SETTLE   | waiting for vec_q to stay unchanged SETTLE_CYC cycles
// S_CHECK    | one-cycle compare of rsp_q against the expected response
// S_WAIT_CHG | waiting for vec_q to move off the vector just checked
// S_DONE     | run complete; results frozen until the next start

module aoi_chk #(
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_CHECKS = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        ina,
  input  logic        inb,
  input  logic        inc,
  input  logic        ind,
  input  logic        oute,
  input  logic        outf,
  input  logic        outg,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] chk_cnt,
  output logic [7:0]  err_cnt,
  output logic [15:0] cov_mask,
  output logic [6:0]  first_err
);

  localparam logic [3:0]  SETTLE_LD = 4'(SETTLE_CYC);
  localparam logic [15:0] MAX_LD    = 16'(MAX_CHECKS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_CHECK,
    S_WAIT_CHG,
    S_DONE
  } state_t;

  state_t      state;
  logic [3:0]  vec_q;
  logic [2:0]  rsp_q;
  logic [3:0]  vec_prev;
  logic [3:0]  last_vec;
  logic [3:0]  stab_tmr;

  logic        exp_e;
  logic        exp_f;
  logic        exp_g;
  logic        mismatch;
  logic [15:0] chk_nxt;
  logic [7:0]  err_nxt;
  logic [15:0] cov_nxt;
  logic        run_end;

  // Single sampling stage; every decision below looks only at these copies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec_q    <= 4'd0;
      rsp_q    <= 3'd0;
      vec_prev <= 4'd0;
    end else begin
      vec_q    <= {ina, inb, inc, ind};
      rsp_q    <= {oute, outf, outg};
      vec_prev <= vec_q;
    end
  end

  always_comb begin
    exp_e    = vec_q[3] & vec_q[2];
    exp_f    = vec_q[1] & vec_q[0];
    exp_g    = ~(exp_e | exp_f);
    mismatch = (rsp_q != {exp_e, exp_f, exp_g});
    chk_nxt  = chk_cnt + 16'd1;
    err_nxt  = (mismatch && (err_cnt != 8'hFF)) ? err_cnt + 8'd1 : err_cnt;
    cov_nxt  = cov_mask | (16'd1 << vec_q);
    run_end  = (cov_nxt == 16'hFFFF) || (chk_nxt == MAX_LD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      chk_cnt   <= 16'd0;
      err_cnt   <= 8'd0;
      cov_mask  <= 16'd0;
      first_err <= 7'd0;
      last_vec  <= 4'd0;
      stab_tmr  <= 4'd0;
    end else if (start) begin
      // A start in any state restarts the run and overrides a pending compare.
      state     <= S_SETTLE;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      chk_cnt   <= 16'd0;
      err_cnt   <= 8'd0;
      cov_mask  <= 16'd0;
      first_err <= 7'd0;
      stab_tmr  <= SETTLE_LD;
    end else begin
      case (state)
        S_IDLE: begin
        end

        S_SETTLE: begin
          if (vec_q == vec_prev) begin
            if (stab_tmr == 4'd1) begin
              state <= S_CHECK;
            end else begin
              stab_tmr <= stab_tmr - 4'd1;
            end
          end else begin
            stab_tmr <= SETTLE_LD;
          end
        end

        S_CHECK: begin
          chk_cnt  <= chk_nxt;
          err_cnt  <= err_nxt;
          cov_mask <= cov_nxt;
          last_vec <= vec_q;
          if (mismatch && (err_cnt == 8'd0)) begin
            first_err <= {vec_q, rsp_q};
          end
          if (run_end) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            pass  <= (err_nxt == 8'd0);
          end else begin
            state <= S_WAIT_CHG;
          end
        end

        S_WAIT_CHG: begin
          if (vec_q != last_vec) begin
            stab_tmr <= SETTLE_LD;
            state    <= S_SETTLE;
          end
        end

        S_DONE: begin
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
          pass  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/aoi_chk.md
AOI_CHK -- requirements
Module: aoi_chk

Interface
REQ-001 Parameter SETTLE_CYC, default 2: consecutive stable sampled cycles required before a vector is checked (legal 1..15).
REQ-002 Parameter MAX_CHECKS, default 1000: check count at which a run terminates (legal 1..65535).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 start  input  1  single-cycle pulse; clears results and begins a run.
REQ-006 ina, inb, inc, ind  input  1 each  stimulus observed at the AOI inputs.
REQ-007 oute, outf, outg  input  1 each  AOI responses under test.
REQ-008 busy  output  1  run in progress (states SETTLE, CHECK, WAIT_CHG).
REQ-009 done  output  1  run finished; high only in state DONE.
REQ-010 pass  output  1  done & (err_cnt == 0).
REQ-011 chk_cnt  output  16  number of checks performed this run.
REQ-012 err_cnt  output  8  mismatching checks, saturating at 255.
REQ-013 cov_mask  output  16  bit i set once vector i = {ina,inb,inc,ind} (ina = MSB) has been checked.
REQ-014 first_err  output  7  {vector[3:0], oute, outf, outg} captured at the first mismatch; 0 if none.

Function
REQ-015 All seven data inputs SHALL be registered once (vec_q, rsp_q); all decisions use the registered copies only.
REQ-016 Expected responses SHALL be: e = ina&inb; f = inc&ind; g = ~(e|f).
REQ-017 States: IDLE, SETTLE, CHECK, WAIT_CHG, DONE; encoding at implementer's discretion.
REQ-018 IDLE: all outputs hold; start -> clear chk_cnt, err_cnt, cov_mask, first_err, stable counter -> SETTLE.
REQ-019 SETTLE: stable counter increments each cycle vec_q equals its previous value, resets to 0 on change; reaching SETTLE_CYC -> CHECK.
REQ-020 CHECK (exactly one cycle): compare rsp_q to expected from vec_q; chk_cnt += 1; set cov_mask[vec_q]; on mismatch err_cnt += 1 (saturating) and, if err_cnt was 0, load first_err.
REQ-021 CHECK exit: if updated cov_mask == 16'hFFFF or updated chk_cnt == MAX_CHECKS -> DONE; else -> WAIT_CHG.
REQ-022 WAIT_CHG: hold until vec_q differs from the vector last checked, then clear stable counter -> SETTLE.
REQ-023 A vector returning to a previously checked value SHALL be rechecked (counts again, cov_mask unchanged).
REQ-024 DONE: results frozen, done = 1; start -> same clearing as REQ-018 -> SETTLE.
REQ-025 start in SETTLE, CHECK or WAIT_CHG SHALL abort and restart the run with REQ-018 clearing; start wins over a same-cycle CHECK update.
REQ-026 chk_cnt SHALL never exceed MAX_CHECKS; err_cnt SHALL stick at 255.
REQ-027 Response change during SETTLE does not restart settling; only vec_q changes do.

Reset
REQ-028 rst_n low SHALL immediately force IDLE, busy = done = pass = 0, all counters, cov_mask, first_err, vec_q, rsp_q = 0, independent of clk.
REQ-029 Reset asserted mid-run SHALL discard the run; after release the block stays in IDLE until start.

Verification
REQ-030 Correct AOI model, inputs walked through all 16 vectors, each held 5 cycles, SETTLE_CYC = 2 -> done after 16th check, chk_cnt = 16, cov_mask = 16'hFFFF, err_cnt = 0, pass = 1.
REQ-031 Model with outg stuck at 0, vector 4'b0000 first -> first_err = 7'b0000_000, err_cnt counts every vector where g should be 1 (9 of 16), pass = 0.
REQ-032 Vector toggling every cycle for 20 cycles -> no CHECK, chk_cnt = 0, busy = 1; then hold -> check occurs exactly SETTLE_CYC + 2 cycles after last change of raw inputs.
REQ-033 MAX_CHECKS = 3, alternating 4'b0000/4'b1111 -> done after 3 checks, cov_mask = 16'h8001.
REQ-034 start pulsed mid-run after 5 checks -> counters clear in next cycle, state SETTLE, prior results lost.
REQ-035 rst_n pulled low between clock edges during CHECK -> outputs zero before next edge; post-release block stays IDLE.
